sap1_controller_sequencer: RTL and testbench
============================================

Name: sap1_controller_sequencer

Overview:
- Control/sequencer for the SAP-1 datapath.
- Contains a 6-state ring counter (T1–T6) and an instruction decoder driven by the upper nibble of the instruction register.
- Produces the control word that drives the load enables (g1/g2, active-low) and output enables (m/n, active-low) of the sn54173 bus registers, plus the PC, RAM, ALU and halt controls.
- Sits directly upstream of every sn54173 register: its _n outputs wire straight to those pins.

Parameters:
- OP_LDA, 4'b0000, opcode for load A from memory
- OP_ADD, 4'b0001, opcode for A = A + B
- OP_SUB, 4'b0010, opcode for A = A - B
- OP_OUT, 4'b1110, opcode for A to output register
- OP_HLT, 4'b1111, opcode for halt

Ports:
- clk  input  1  system clock; registers load on rising edge, sequencer advances on falling edge
- clr  input  1  synchronous active-high reset, sampled on falling edge of clk
- opcode  input  4  IR[7:4], stable from rising edge in T3 onward
- t_state  output  6  one-hot ring state, bit0=T1 … bit5=T6
- cp  output  1  PC count enable
- ep  output  1  PC bus enable
- lm_n  output  1  MAR load, active-low
- ce_n  output  1  RAM bus enable, active-low
- li_n  output  1  IR load, active-low
- ei_n  output  1  IR operand bus enable, active-low
- la_n  output  1  A load, active-low
- ea  output  1  A bus enable
- su  output  1  ALU subtract select
- eu  output  1  ALU bus enable
- lb_n  output  1  B load, active-low
- lo_n  output  1  output register load, active-low
- hlt  output  1  halt indicator; gates clock externally

Behaviour:
- **Clock and reset:** One clock, clk. Reset is synchronous and active-high: clr sampled at the falling edge of clk.
- **State register:**
  - Only state is the one-hot ring, updated on falling edges only.
  - Control outputs change half a cycle before the register-loading rising edge.
- **Reset:**
  - clr=1 at a falling edge: t_state=6'b000001 (T1).
  - While clr=1, all outputs are forced inactive: cp=ep=ea=su=eu=hlt=0, all _n outputs=1.
  - Release shows the T1 word combinationally.
  - clr mid-instruction aborts the instruction at the next falling edge; no partial state is retained.
- **Ring sequence:** Advances T1→T2→…→T6→T1 on each falling edge when clr=0 and not halted. One instruction takes exactly 6 clocks.
- **Fetch (all opcodes):**
  - T1: ep=1, lm_n=0
  - T2: cp=1
  - T3: ce_n=0, li_n=0
- **Execute:**
  - LDA: T4 ei_n=0, lm_n=0; T5 ce_n=0, la_n=0; T6 none.
  - ADD: T4 ei_n=0, lm_n=0; T5 ce_n=0, lb_n=0; T6 eu=1, la_n=0, su=0.
  - SUB: same as ADD, but su=1 in T6 only.
  - OUT: T4 ea=1, lo_n=0; T5 and T6 none.
  - HLT: at T4, hlt=1 and all other controls are inactive. The ring holds at T4 indefinitely; hlt stays 1 until clr.
  - Undefined opcodes: T4–T6 all controls inactive (NOP), ring continues normally.
- **Output rules:**
  - Outputs are purely combinational from (t_state, opcode, clr).
  - Any control not listed for a state takes its inactive value.
  - At most one bus driver is active (ep, ce_n=0, ei_n=0, ea, eu) in any state; assertion-checkable.
- **Boundary conditions:**
  - An opcode change during T4–T6 alters the word immediately (decode is not latched); the IR holds it stable in correct systems.
  - clr and halt together: clr wins and returns to T1 with hlt=0.

Test Plan:
- Reset: clr=1 for 2 falling edges, then 0 → t_state=000001, ep=1, lm_n=0; during clr all _n=1 and hlt=0.
- LDA: opcode=0000 for 6 clocks → t_state walks 000001…100000→000001. T4 ei_n=lm_n=0; T5 ce_n=la_n=0; T6 all inactive.
- SUB: opcode=0010 → T5 lb_n=0, ce_n=0; T6 eu=1, la_n=0, su=1. su=0 in all other states.
- HLT: opcode=1111 → hlt=1 at T4; t_state stays 001000 for 20 clocks. Then clr=1 → t_state=000001, hlt=0.
- Abort: opcode=0001, assert clr during T5 → next falling edge gives T1; lb_n returns to 1 immediately on clr.
- NOP/mutual exclusion: opcode=0111 → T4–T6 all inactive. Across all opcodes and states, at most one bus enable is active.

Source files
------------

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller/sequencer: six-state ring counter advanced on the falling edge plus
// an opcode decoder. The control word is combinational, so it settles half a cycle
// before the rising edge that loads the registers.
module sap1_controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] opcode,
  output logic [5:0] t_state,
  output logic       cp,
  output logic       ep,
  output logic       lm_n,
  output logic       ce_n,
  output logic       li_n,
  output logic       ei_n,
  output logic       la_n,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb_n,
  output logic       lo_n,
  output logic       hlt
);

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  logic halt_hold;
  assign halt_hold = (t_state == T4) && (opcode == OP_HLT);

  // Falling-edge ring; a corrupted (non one-hot) value falls back to T1.
  always_ff @(negedge clk) begin
    if (clr) begin
      t_state <= T1;
    end else if (!$onehot(t_state)) begin
      t_state <= T1;
    end else if (!halt_hold) begin
      t_state <= {t_state[4:0], t_state[5]};
    end
  end

  always_comb begin
    cp   = 1'b0;
    ep   = 1'b0;
    lm_n = 1'b1;
    ce_n = 1'b1;
    li_n = 1'b1;
    ei_n = 1'b1;
    la_n = 1'b1;
    ea   = 1'b0;
    su   = 1'b0;
    eu   = 1'b0;
    lb_n = 1'b1;
    lo_n = 1'b1;
    hlt  = 1'b0;
    if (!clr) begin
      case (t_state)
        T1: begin
          ep   = 1'b1;
          lm_n = 1'b0;
        end
        T2: cp = 1'b1;
        T3: begin
          ce_n = 1'b0;
          li_n = 1'b0;
        end
        T4: begin
          // Decode is not latched: the IR is relied on to hold the opcode.
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            ei_n = 1'b0;
            lm_n = 1'b0;
          end else if (opcode == OP_OUT) begin
            ea   = 1'b1;
            lo_n = 1'b0;
          end else if (opcode == OP_HLT) begin
            hlt  = 1'b1;
          end
        end
        T5: begin
          if (opcode == OP_LDA) begin
            ce_n = 1'b0;
            la_n = 1'b0;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            ce_n = 1'b0;
            lb_n = 1'b0;
          end
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            eu   = 1'b1;
            la_n = 1'b0;
            su   = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Directed bench for the SAP-1 sequencer: ring walk, per-opcode control words,
// halt hold, clear abort and bus-driver exclusivity.
module tb_sap1_controller_sequencer;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] opcode = 4'b0000;
  logic [5:0] t_state;
  logic cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n, hlt;

  int n_cmp = 0;
  int n_bad = 0;

  sap1_controller_sequencer dut (
    .clk(clk), .clr(clr), .opcode(opcode), .t_state(t_state),
    .cp(cp), .ep(ep), .lm_n(lm_n), .ce_n(ce_n), .li_n(li_n), .ei_n(ei_n),
    .la_n(la_n), .ea(ea), .su(su), .eu(eu), .lb_n(lb_n), .lo_n(lo_n), .hlt(hlt)
  );

  always #50 clk = ~clk;

  // Word order: cp ep lm_n ce_n li_n ei_n la_n ea su eu lb_n lo_n hlt
  logic [12:0] ctrl;
  logic [2:0]  nbus;
  assign ctrl = {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n, hlt};
  assign nbus = 3'(ep) + 3'(!ce_n) + 3'(!ei_n) + 3'(ea) + 3'(eu);

  localparam logic [12:0] W_IDLE = 13'b0_0_1_1_1_1_1_0_0_0_1_1_0;
  localparam logic [12:0] W_T1   = 13'b0_1_0_1_1_1_1_0_0_0_1_1_0;
  localparam logic [12:0] W_T2   = 13'b1_0_1_1_1_1_1_0_0_0_1_1_0;
  localparam logic [12:0] W_T3   = 13'b0_0_1_0_0_1_1_0_0_0_1_1_0;
  localparam logic [12:0] W_MEM4 = 13'b0_0_0_1_1_0_1_0_0_0_1_1_0;
  localparam logic [12:0] W_LDA5 = 13'b0_0_1_0_1_1_0_0_0_0_1_1_0;
  localparam logic [12:0] W_ADD5 = 13'b0_0_1_0_1_1_1_0_0_0_0_1_0;
  localparam logic [12:0] W_ADD6 = 13'b0_0_1_1_1_1_0_0_0_1_1_1_0;
  localparam logic [12:0] W_SUB6 = 13'b0_0_1_1_1_1_0_0_1_1_1_1_0;
  localparam logic [12:0] W_OUT4 = 13'b0_0_1_1_1_1_1_1_0_0_1_0_0;
  localparam logic [12:0] W_HLT4 = 13'b0_0_1_1_1_1_1_0_0_0_1_1_1;

  // Advance one full clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    opcode = 4'b0000;
    tick();
    tick();
    n_cmp++; if (t_state !== 6'b000001) begin n_bad++; $display("FAIL reset_state got %b want 000001", t_state); end
    n_cmp++; if (ctrl !== W_IDLE) begin n_bad++; $display("FAIL reset_word got %b want %b", ctrl, W_IDLE); end
    clr = 1'b0;
    #1;
    n_cmp++; if (ctrl !== W_T1) begin n_bad++; $display("FAIL release_word got %b want %b", ctrl, W_T1); end
  endtask

  task automatic test_lda();
    logic [12:0] exp [6];
    exp = '{W_T1, W_T2, W_T3, W_MEM4, W_LDA5, W_IDLE};
    opcode = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (t_state !== 6'(1 << k)) begin n_bad++; $display("FAIL lda_state T%0d got %b want %b", k + 1, t_state, 6'(1 << k)); end
      n_cmp++; if (ctrl !== exp[k]) begin n_bad++; $display("FAIL lda_word T%0d got %b want %b", k + 1, ctrl, exp[k]); end
      tick();
    end
    n_cmp++; if (t_state !== 6'b000001) begin n_bad++; $display("FAIL lda_wrap got %b want 000001", t_state); end
  endtask

  task automatic test_sub();
    logic [12:0] exp [6];
    exp = '{W_T1, W_T2, W_T3, W_MEM4, W_ADD5, W_SUB6};
    opcode = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (t_state !== 6'(1 << k)) begin n_bad++; $display("FAIL sub_state T%0d got %b want %b", k + 1, t_state, 6'(1 << k)); end
      n_cmp++; if (ctrl !== exp[k]) begin n_bad++; $display("FAIL sub_word T%0d got %b want %b", k + 1, ctrl, exp[k]); end
      tick();
    end
    n_cmp++; if (t_state !== 6'b000001) begin n_bad++; $display("FAIL sub_wrap got %b want 000001", t_state); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [3];
    logic [12:0] exp [3][6];
    ops = '{4'b0001, 4'b1110, 4'b0000};
    exp = '{'{W_T1, W_T2, W_T3, W_MEM4, W_ADD5, W_ADD6},
            '{W_T1, W_T2, W_T3, W_OUT4, W_IDLE, W_IDLE},
            '{W_T1, W_T2, W_T3, W_MEM4, W_LDA5, W_IDLE}};
    for (int i = 0; i < 3; i++) begin
      opcode = ops[i];
      for (int k = 0; k < 6; k++) begin
        #1;
        n_cmp++; if (t_state !== 6'(1 << k)) begin n_bad++; $display("FAIL b2b_state op%0d T%0d got %b want %b", i, k + 1, t_state, 6'(1 << k)); end
        n_cmp++; if (ctrl !== exp[i][k]) begin n_bad++; $display("FAIL b2b_word op%0d T%0d got %b want %b", i, k + 1, ctrl, exp[i][k]); end
        tick();
      end
    end
  endtask

  task automatic test_opcode_change();
    opcode = 4'b0000;
    tick(); tick(); tick();
    n_cmp++; if (ctrl !== W_MEM4) begin n_bad++; $display("FAIL chg_lda4 got %b want %b", ctrl, W_MEM4); end
    opcode = 4'b1110;
    #1;
    n_cmp++; if (ctrl !== W_OUT4) begin n_bad++; $display("FAIL chg_out4 got %b want %b", ctrl, W_OUT4); end
    opcode = 4'b0000;
    tick(); tick(); tick();
    n_cmp++; if (t_state !== 6'b000001) begin n_bad++; $display("FAIL chg_wrap got %b want 000001", t_state); end
  endtask

  task automatic test_hlt();
    int stuck;
    opcode = 4'b1111;
    tick(); tick(); tick();
    n_cmp++; if (ctrl !== W_HLT4) begin n_bad++; $display("FAIL hlt_word got %b want %b", ctrl, W_HLT4); end
    stuck = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (t_state !== 6'b001000 || hlt !== 1'b1) stuck++;
    end
    n_cmp++; if (stuck !== 0) begin n_bad++; $display("FAIL hlt_hold cycles_off_T4 got %0d want 0", stuck); end
    n_cmp++; if (t_state !== 6'b001000) begin n_bad++; $display("FAIL hlt_state got %b want 001000", t_state); end
    clr = 1'b1;
    #1;
    n_cmp++; if (hlt !== 1'b0) begin n_bad++; $display("FAIL hlt_clr_comb got %b want 0", hlt); end
    tick();
    n_cmp++; if (t_state !== 6'b000001) begin n_bad++; $display("FAIL hlt_clr_state got %b want 000001", t_state); end
    clr = 1'b0;
    opcode = 4'b0000;
    #1;
    n_cmp++; if (ctrl !== W_T1) begin n_bad++; $display("FAIL hlt_release got %b want %b", ctrl, W_T1); end
  endtask

  task automatic test_abort();
    opcode = 4'b0001;
    tick(); tick(); tick(); tick();
    n_cmp++; if (t_state !== 6'b010000 || lb_n !== 1'b0) begin n_bad++; $display("FAIL abort_t5 got state %b lb_n %b want 010000 0", t_state, lb_n); end
    clr = 1'b1;
    #1;
    n_cmp++; if (lb_n !== 1'b1) begin n_bad++; $display("FAIL abort_lb_n got %b want 1", lb_n); end
    tick();
    n_cmp++; if (t_state !== 6'b000001) begin n_bad++; $display("FAIL abort_state got %b want 000001", t_state); end
    clr = 1'b0;
    #1;
    n_cmp++; if (ctrl !== W_T1) begin n_bad++; $display("FAIL abort_release got %b want %b", ctrl, W_T1); end
  endtask

  task automatic test_nop_mutex();
    int multi;
    multi = 0;
    opcode = 4'b0111;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (k >= 3) begin
        n_cmp++; if (ctrl !== W_IDLE) begin n_bad++; $display("FAIL nop_word T%0d got %b want %b", k + 1, ctrl, W_IDLE); end
      end
      for (int op = 0; op < 16; op++) begin
        opcode = 4'(op);
        #1;
        if (nbus > 3'd1) begin
          multi++;
          $display("FAIL mutex T%0d op %b drivers got %0d want <=1", k + 1, opcode, nbus);
        end
      end
      opcode = 4'b0111;
      tick();
    end
    n_cmp++; if (multi !== 0) begin n_bad++; $display("FAIL mutex_total got %0d want 0", multi); end
    n_cmp++; if (t_state !== 6'b000001) begin n_bad++; $display("FAIL nop_wrap got %b want 000001", t_state); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lda();
    test_sub();
    test_back_to_back();
    test_opcode_change();
    test_hlt();
    test_abort();
    test_nop_mutex();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
